traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
- Downstream safety stage for the traffic light controller. It consumes the controller's red/yellow/green lamp requests and its enable.
- Checks phase encoding, phase order and dwell times against the controller's fixed timing.
- Drives the physical lamp outputs. On any violation it latches a sticky fault and forces the lamps to flashing yellow until software clears the fault.

Parameters:
- IDLE_CYCLES, 32, enabled cycles spent in IDLE (all lamps off)
- GREEN_CYCLES, 20, enabled cycles spent in GREEN
- YELLOW_CYCLES, 7, enabled cycles spent in YELLOW
- RED_CYCLES, 1, enabled cycles spent in RED
- BLINK_HALF, 16, half period of the fault flash, in clk cycles
- DWELL_W, 6, dwell counter width (must hold max(*_CYCLES)+1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  same enable that drives the controller; dwell is counted only in enabled cycles
- red_in  in  1  controller red request
- yellow_in  in  1  controller yellow request
- green_in  in  1  controller green request
- fault_clear  in  1  single-cycle pulse; clears the latched fault
- lamp_red  out  1  physical red lamp
- lamp_yellow  out  1  physical yellow lamp
- lamp_green  out  1  physical green lamp
- fault  out  1  sticky fault flag
- fault_code  out  3  first-fault cause: 0 none, 1 ILLEGAL_ENC, 2 BAD_TRANS, 3 DWELL_SHORT, 4 DWELL_LONG
- seq_count  out  16  completed legal sequences, saturating at 0xFFFF

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in TRACK, tracked phase IDLE, dwell 0, blink counter 0.
  - These values match the controller's reset state.
- Phase decode of the inputs each cycle:
  - none set -> IDLE; exactly one set -> RED, YELLOW or GREEN.
  - More than one set -> illegal.
- Legal phase order: IDLE->GREEN->YELLOW->RED->IDLE.
- Dwell counting: dwell increments on every cycle where enable=1 and the decoded phase equals the tracked phase. Cycles with enable=0 hold dwell.
- Phase change (decoded phase differs from tracked phase, sampled regardless of enable):
  - Check legality. An illegal next phase gives BAD_TRANS.
  - Check dwell against the tracked phase's *_CYCLES. dwell < expected gives DWELL_SHORT.
  - If both checks pass: tracked phase <= new phase and dwell <= 1 if enable else 0.
  - A legal RED->IDLE change increments seq_count, saturating at 0xFFFF.
- Overrun: if the phase is unchanged, enable=1 and dwell already equals expected, the result is DWELL_LONG.
- Illegal encoding gives ILLEGAL_ENC. It takes priority over all other checks in the same cycle.
- FSM states and transitions:
  - TRACK: performs all checks. Any violation -> FAULT.
  - FAULT:
    - fault=1; fault_code holds the first cause only.
    - Lamps: red=0, green=0, yellow toggles every BLINK_HALF cycles, starting on in the first FAULT cycle.
    - fault_clear -> RESYNC.
  - RESYNC:
    - fault=0, fault_code=0.
    - Tracked phase is loaded from the current decoded phase.
    - Encoding is still checked; dwell and order checks are suppressed.
    - On the first legal-order phase change, enter TRACK with dwell restarted as above.
    - Illegal encoding -> FAULT.
- Latency: fault, fault_code and lamp outputs are registered. They reflect a sample one clk later.
- Lamp outputs in TRACK/RESYNC are the registered inputs (1-cycle latency).
- Simultaneous fault_clear and a new violation: the clear wins and the violation is ignored that cycle.
- fault_clear outside FAULT has no effect.
- reset mid-operation returns to reset values in the next cycle, including seq_count.

Decomposition:
- Shared package traffic_light_pkg holds:
  - phase encoding (IDLE/RED/GREEN/YELLOW, 2-bit, same values as the controller)
  - fault code constants
  - a next-legal-phase function
  - the default cycle constants
- One sub-module, fault_blinker: BLINK_HALF counter producing the flashing yellow. It is enabled only in FAULT and reset on entry.

Test Plan:
- Reset, enable=1 driven by the real controller for 2 full sequences (≈120 cycles) -> fault=0, seq_count=2, lamps equal the inputs delayed 1 cycle.
- Same as above with enable toggling 1-in-3 -> fault=0, seq_count=2, dwell held during enable=0.
- Stub drives green for 19 enabled cycles then yellow -> fault=1, fault_code=3 one cycle after the change, lamp_yellow flashing 16 on/16 off, red and green 0.
- Stub holds green for 21 enabled cycles -> fault_code=4 registered after the 21st sample; a later ILLEGAL_ENC keeps fault_code=4.
- Stub drives red_in=green_in=1 for 1 cycle from IDLE -> fault_code=1 next cycle.
- Stub drives green->red -> fault_code=2. Then pulse fault_clear while a violation is present -> fault=0 the next cycle, RESYNC; the next legal change re-enters TRACK and a clean sequence then increments seq_count.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light controller and its safety monitor:
// phase encoding, fault causes, monitor states and the legal phase order.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_RED    = 2'd1,
    PH_GREEN  = 2'd2,
    PH_YELLOW = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    FC_NONE        = 3'd0,
    FC_ILLEGAL_ENC = 3'd1,
    FC_BAD_TRANS   = 3'd2,
    FC_DWELL_SHORT = 3'd3,
    FC_DWELL_LONG  = 3'd4
  } fault_code_t;

  typedef enum logic [1:0] {
    ST_TRACK  = 2'd0,
    ST_FAULT  = 2'd1,
    ST_RESYNC = 2'd2
  } mon_state_t;

  localparam int IDLE_CYCLES_DEF   = 32;
  localparam int GREEN_CYCLES_DEF  = 20;
  localparam int YELLOW_CYCLES_DEF = 7;
  localparam int RED_CYCLES_DEF    = 1;

  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_IDLE:   return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp request / lamp drive bundle between the controller side and the monitor.
interface traffic_light_monitor_if;
  logic        enable;
  logic        red_in;
  logic        yellow_in;
  logic        green_in;
  logic        fault_clear;
  logic        lamp_red;
  logic        lamp_yellow;
  logic        lamp_green;
  logic        fault;
  logic [2:0]  fault_code;
  logic [15:0] seq_count;

  modport master (
    output enable, red_in, yellow_in, green_in, fault_clear,
    input  lamp_red, lamp_yellow, lamp_green, fault, fault_code, seq_count
  );

  modport slave (
    input  enable, red_in, yellow_in, green_in, fault_clear,
    output lamp_red, lamp_yellow, lamp_green, fault, fault_code, seq_count
  );
endinterface

// File: rtl/fault_blinker.sv
// Flashing-yellow generator: restarts "on" at fault entry, then toggles every
// BLINK_HALF cycles while the monitor stays in FAULT.
module fault_blinker #(
  parameter int BLINK_HALF = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic blink
);
  localparam int CW = $clog2(BLINK_HALF + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      blink <= 1'b1;
    end else if (run) begin
      if (cnt == CW'(BLINK_HALF - 1)) begin
        cnt   <= '0;
        blink <= ~blink;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/traffic_light_monitor.sv
// Safety stage behind the traffic light controller: checks encoding, order and
// dwell of the lamp requests, drives the lamps and latches the first fault.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int IDLE_CYCLES   = IDLE_CYCLES_DEF,
  parameter int GREEN_CYCLES  = GREEN_CYCLES_DEF,
  parameter int YELLOW_CYCLES = YELLOW_CYCLES_DEF,
  parameter int RED_CYCLES    = RED_CYCLES_DEF,
  parameter int BLINK_HALF    = 16,
  parameter int DWELL_W       = 6
) (
  input  logic clk,
  input  logic reset,
  traffic_light_monitor_if.slave bus
);
  mon_state_t   state, state_nxt;
  phase_t       tracked, tracked_nxt, dec;
  logic         illegal;
  logic [DWELL_W-1:0] dwell, dwell_nxt, expected;
  fault_code_t  cause, code;
  logic         seq_inc;
  logic [15:0]  seq;
  logic         red_p1, yellow_p1, green_p1;
  logic         blink;

  always_comb begin
    illegal = 1'b0;
    dec     = PH_IDLE;
    case ({bus.red_in, bus.yellow_in, bus.green_in})
      3'b000:  dec = PH_IDLE;
      3'b100:  dec = PH_RED;
      3'b010:  dec = PH_YELLOW;
      3'b001:  dec = PH_GREEN;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (tracked)
      PH_IDLE:   expected = DWELL_W'(IDLE_CYCLES);
      PH_GREEN:  expected = DWELL_W'(GREEN_CYCLES);
      PH_YELLOW: expected = DWELL_W'(YELLOW_CYCLES);
      default:   expected = DWELL_W'(RED_CYCLES);
    endcase
  end

  always_comb begin
    state_nxt   = state;
    tracked_nxt = tracked;
    dwell_nxt   = dwell;
    cause       = FC_NONE;
    seq_inc     = 1'b0;
    case (state)
      ST_TRACK: begin
        if (illegal) begin
          cause = FC_ILLEGAL_ENC;
        end else if (dec != tracked) begin
          if (dec != next_phase(tracked)) begin
            cause = FC_BAD_TRANS;
          end else if (dwell < expected) begin
            cause = FC_DWELL_SHORT;
          end else begin
            tracked_nxt = dec;
            dwell_nxt   = bus.enable ? DWELL_W'(1) : '0;
            seq_inc     = (tracked == PH_RED);
          end
        end else if (bus.enable) begin
          if (dwell == expected) cause = FC_DWELL_LONG;
          else                   dwell_nxt = dwell + DWELL_W'(1);
        end
        if (cause != FC_NONE) state_nxt = ST_FAULT;
      end
      ST_FAULT: begin
        // A clear overrides whatever violation is present in the same cycle.
        if (bus.fault_clear) begin
          state_nxt = ST_RESYNC;
          if (!illegal) tracked_nxt = dec;
        end
      end
      ST_RESYNC: begin
        if (illegal) begin
          cause     = FC_ILLEGAL_ENC;
          state_nxt = ST_FAULT;
        end else begin
          tracked_nxt = dec;
          if (dec != tracked && dec == next_phase(tracked)) begin
            state_nxt = ST_TRACK;
            dwell_nxt = bus.enable ? DWELL_W'(1) : '0;
          end
        end
      end
      default: state_nxt = ST_TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_TRACK;
      tracked   <= PH_IDLE;
      dwell     <= '0;
      code      <= FC_NONE;
      seq       <= '0;
      red_p1    <= 1'b0;
      yellow_p1 <= 1'b0;
      green_p1  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tracked   <= tracked_nxt;
      dwell     <= dwell_nxt;
      red_p1    <= bus.red_in;
      yellow_p1 <= bus.yellow_in;
      green_p1  <= bus.green_in;
      if (state != ST_FAULT && state_nxt == ST_FAULT) code <= cause;
      else if (state_nxt != ST_FAULT)                 code <= FC_NONE;
      if (seq_inc && seq != 16'hFFFF) seq <= seq + 16'd1;
    end
  end

  fault_blinker #(.BLINK_HALF(BLINK_HALF)) u_blinker (
    .clk   (clk),
    .reset (reset),
    .start (state != ST_FAULT && state_nxt == ST_FAULT),
    .run   (state == ST_FAULT),
    .blink (blink)
  );

  assign bus.fault       = (state == ST_FAULT);
  assign bus.fault_code  = code;
  assign bus.seq_count   = seq;
  assign bus.lamp_red    = (state == ST_FAULT) ? 1'b0  : red_p1;
  assign bus.lamp_green  = (state == ST_FAULT) ? 1'b0  : green_p1;
  assign bus.lamp_yellow = (state == ST_FAULT) ? blink : yellow_p1;
endmodule
